stopwatch_display_driver: RTL and testbench
===========================================

Name: stopwatch_display_driver

Overview:
- Consumes the slow square wave from the clock divider, e.g. 1 Hz, and runs a 4-digit BCD MM:SS stopwatch from it.
- Drives a multiplexed, common-anode, 4-digit seven-segment display.
- All logic runs in the clk_in domain. The divided clock is treated as data: it is synchronized and edge-detected, never used as a clock.
- Sits between the clock divider and the board display pins.

Parameters:
- REFRESH_DIV, default 50_000: clk_in cycles per digit-select step. At 50 MHz this gives 1 kHz per digit.
- REFRESH_W, default $clog2(REFRESH_DIV): width of the refresh counter. Derived; not overridden.

Ports:
- clk_in  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- tick_clk  input  1  divided clock from the divider; asynchronous to this block's sampling.
- run  input  1  1 = count on each tick_clk rising edge; 0 = hold.
- clear  input  1  synchronous clear of the time digits only.
- digits  output  16  BCD time {min_tens, min_units, sec_tens, sec_units}, 4 bits each.
- wrap  output  1  one-cycle pulse when the time rolls 59:59 -> 00:00.
- an  output  4  digit anodes, active-low, one-hot-low.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.

Behaviour:
- Interface: clock clk_in; reset reset, synchronous, active-high.
- Sync and edge detect:
  - s1 <= tick_clk; s2 <= s1; s3 <= s2.
  - tick_pe = s2 & ~s3.
  - Reset sets s1, s2, s3 to 0. A tick_clk that is high at reset release therefore produces one tick_pe.
- Latency: a tick_clk rise before clk_in edge k shows up in digits after edge k+2.
  - k captures s1, k+1 captures s2, k+2 updates the counter.
- Counter update priority, evaluated each clk_in edge:
  - reset, then clear, then (tick_pe & run), then hold.
- Increment:
  - sec_units counts 0..9. Carry into sec_tens counts 0..5, carry into min_units 0..9, carry into min_tens 0..5.
  - At 59:59 an increment gives 00:00, and wrap=1 for exactly that one cycle.
- clear:
  - Sets digits=0000 and wrap=0.
  - Does not affect the refresh counter or the digit select.
  - If clear and tick_pe occur in the same cycle, the tick is dropped.
- run=0: tick_pe is ignored; no increment and no wrap.
- Refresh counter rc:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - When rc == REFRESH_DIV-1, the select sel (2 bits) advances 0->1->2->3->0.
  - Free-running; unaffected by run and clear.
- Display outputs are a combinational decode of the registered sel and digits:
  - sel=0: an=1110, shows sec_units.
  - sel=1: an=1101, shows sec_tens.
  - sel=2: an=1011, shows min_units.
  - sel=3: an=0111, shows min_tens.
  - dp=0 only when sel==2 (point between minutes and seconds); otherwise dp=1.
- Seven-segment decode (seg):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - BCD 10..15 are unreachable; decode them to 1111111 (blank).
- Reset values: digits=0, wrap=0, rc=0, sel=0, an=1110, seg=1000000, dp=1.
- Reset mid-operation:
  - All state returns to the reset values on the next edge.
  - A pending tick in the synchronizer is discarded.
- Constraints:
  - tick_clk high and low periods must each be at least 3 clk_in cycles; shorter pulses may be missed.
  - Each tick_clk rise gives at most one increment.

Test Plan:
- Reset then count: REFRESH_DIV=4; assert reset 2 cycles; run=1; apply 10 tick_clk rises, each 8 cycles high and 8 low -> digits=16'h0010, and wrap never asserted.
- Latency check: raise tick_clk just before edge k -> digits changes 0000->0001 at edge k+2, not earlier.
- Rollover: preload by 3599 ticks to 59:59 (16'h5959), then one more tick -> digits=16'h0000 and wrap high for exactly 1 cycle.
- Run and clear: at 00:07, set run=0 and apply 3 ticks -> stays 16'h0007. Assert clear in the same cycle as tick_pe -> digits=16'h0000 and no increment.
- Mux scan: digits=16'h1234, REFRESH_DIV=4 -> the pattern advances every 4 cycles:
  - an 1110 with seg=0011001 ('4'), dp=1;
  - an 1101 with seg=0110000 ('3'), dp=1;
  - an 1011 with seg=0100100 ('2'), dp=0;
  - an 0111 with seg=1111001 ('1'), dp=1.
- Reset mid-count: at 12:34, with a tick held in s1/s2, assert reset -> next cycle digits=0, an=1110, seg=1000000. The held tick causes no increment after reset release unless tick_clk is still high.

Source files
------------

// File: rtl/stopwatch_display_driver.sv
// MM:SS BCD stopwatch fed by a divided clock sampled as data,
// driving a multiplexed common-anode 4-digit seven-segment display.
module stopwatch_display_driver #(
  parameter  int REFRESH_DIV = 50_000,
  localparam int REFRESH_W   = $clog2(REFRESH_DIV)
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        tick_clk,
  input  logic        run,
  input  logic        clear,
  output logic [15:0] digits,
  output logic        wrap,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  logic [2:0]           sync_q;
  logic                 tick_pe;
  logic [3:0]           su_q, st_q, mu_q, mt_q;
  logic [3:0]           su_d, st_d, mu_d, mt_d;
  logic                 wrap_q, wrap_d;
  logic [REFRESH_W-1:0] rc_q, rc_d;
  logic [1:0]           sel_q, sel_d;
  logic                 rc_last;
  logic [3:0]           nib;

  assign tick_pe = sync_q[1] & ~sync_q[2];

  always_comb begin
    su_d   = su_q;
    st_d   = st_q;
    mu_d   = mu_q;
    mt_d   = mt_q;
    wrap_d = 1'b0;
    if (clear) begin
      su_d = '0;
      st_d = '0;
      mu_d = '0;
      mt_d = '0;
    end else if (tick_pe && run) begin
      if (su_q != 4'd9) begin
        su_d = su_q + 4'd1;
      end else begin
        su_d = '0;
        if (st_q != 4'd5) begin
          st_d = st_q + 4'd1;
        end else begin
          st_d = '0;
          if (mu_q != 4'd9) begin
            mu_d = mu_q + 4'd1;
          end else begin
            mu_d = '0;
            if (mt_q != 4'd5) begin
              mt_d = mt_q + 4'd1;
            end else begin
              mt_d   = '0;
              wrap_d = 1'b1;
            end
          end
        end
      end
    end
  end

  // Digit scan runs regardless of run/clear.
  assign rc_last = (rc_q == REFRESH_W'(REFRESH_DIV - 1));

  always_comb begin
    rc_d  = rc_q + 1'b1;
    sel_d = sel_q;
    if (rc_last) begin
      rc_d  = '0;
      sel_d = sel_q + 2'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      sync_q <= '0;
      su_q   <= '0;
      st_q   <= '0;
      mu_q   <= '0;
      mt_q   <= '0;
      wrap_q <= 1'b0;
      rc_q   <= '0;
      sel_q  <= '0;
    end else begin
      sync_q <= {sync_q[1:0], tick_clk};
      su_q   <= su_d;
      st_q   <= st_d;
      mu_q   <= mu_d;
      mt_q   <= mt_d;
      wrap_q <= wrap_d;
      rc_q   <= rc_d;
      sel_q  <= sel_d;
    end
  end

  assign digits = {mt_q, mu_q, st_q, su_q};
  assign wrap   = wrap_q;

  always_comb begin
    an  = 4'b1110;
    nib = su_q;
    unique case (sel_q)
      2'd0: begin an = 4'b1110; nib = su_q; end
      2'd1: begin an = 4'b1101; nib = st_q; end
      2'd2: begin an = 4'b1011; nib = mu_q; end
      2'd3: begin an = 4'b0111; nib = mt_q; end
    endcase
  end

  assign dp = (sel_q != 2'd2);

  always_comb begin
    seg = 7'b1111111;
    unique case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Scoreboard bench for stopwatch_display_driver: stimulus pushes
// expected digit changes, wrap pulses and output snapshots.
`timescale 1ns/1ps
module tb_stopwatch_display_driver;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        tick_clk;
  logic        run;
  logic        clear;
  logic [15:0] digits;
  logic        wrap;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  stopwatch_display_driver #(.REFRESH_DIV(4)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .tick_clk (tick_clk),
    .run      (run),
    .clear    (clear),
    .digits   (digits),
    .wrap     (wrap),
    .an       (an),
    .seg      (seg),
    .dp       (dp)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    string       name;
    logic [15:0] d;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } snap_t;

  logic [6:0] SEG_TAB [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  int          checks = 0;
  int          errors = 0;
  int          ncyc = 0;
  int          cnt = 0;
  int          wrap_exp = 0;
  bit          armed = 0;
  logic        wrap_prev = 1'b0;
  logic [15:0] prev_dig;
  logic [15:0] last_exp;
  logic [15:0] dig_q [$];
  snap_t       snap_q [$];

  // Cycles since reset release; the scan select is (ncyc/4)%4.
  always @(posedge clk_in) ncyc <= reset ? 0 : ncyc + 1;

  function automatic logic [15:0] bcd(int n);
    return {4'(n / 600), 4'((n / 60) % 10), 4'((n % 60) / 10), 4'(n % 10)};
  endfunction

  task automatic push_cnt(int n);
    cnt = n;
    if (bcd(n) != last_exp) begin
      dig_q.push_back(bcd(n));
      last_exp = bcd(n);
    end
  endtask

  task automatic snap(string nm, logic [15:0] d);
    snap_t s;
    int    sel;
    logic [15:0] sh;
    sel    = (ncyc / 4) % 4;
    sh     = d >> (4 * sel);
    s.name = nm;
    s.d    = d;
    s.an   = ~(4'b0001 << sel);
    s.seg  = SEG_TAB[int'(sh[3:0])];
    s.dp   = (sel != 2);
    snap_q.push_back(s);
  endtask

  task automatic tick(int hi, int lo);
    tick_clk = 1'b1;
    if (run && !clear) begin
      push_cnt((cnt + 1) % 3600);
      if (cnt == 0) wrap_exp++;
    end
    repeat (hi) @(posedge clk_in);
    #1 tick_clk = 1'b0;
    repeat (lo) @(posedge clk_in);
    #1;
  endtask

  task automatic scan(string nm, logic [15:0] d);
    do begin
      @(posedge clk_in);
      #1;
    end while ((ncyc % 16) != 0);
    for (int p = 0; p < 4; p++) begin
      snap($sformatf("%s_ph%0d", nm, p), d);
      repeat (4) @(posedge clk_in);
      #1;
    end
  endtask

  always @(negedge clk_in) begin
    if (armed) begin
      if (digits !== prev_dig) begin
        checks++;
        if (dig_q.size() == 0) begin
          errors++;
          $display("FAIL digit_change: got %h, none expected", digits);
        end else begin
          logic [15:0] e;
          e = dig_q.pop_front();
          if (digits !== e) begin
            errors++;
            $display("FAIL digit_change: got %h, want %h", digits, e);
          end
        end
        prev_dig = digits;
      end
      if (wrap === 1'b1) begin
        checks++;
        if (wrap_exp == 0 || wrap_prev || digits !== 16'h0000) begin
          errors++;
          $display("FAIL wrap_pulse: wrap=1 prev=%b digits=%h pending=%0d",
                   wrap_prev, digits, wrap_exp);
        end
        if (wrap_exp > 0) wrap_exp--;
      end
      wrap_prev = wrap;
    end
    while (snap_q.size() > 0) begin
      snap_t s;
      s = snap_q.pop_front();
      checks++;
      if (digits !== s.d || an !== s.an || seg !== s.seg ||
          dp !== s.dp || wrap !== 1'b0) begin
        errors++;
        $display("FAIL %s: got d=%h an=%b seg=%b dp=%b wrap=%b, want d=%h an=%b seg=%b dp=%b wrap=0",
                 s.name, digits, an, seg, dp, wrap, s.d, s.an, s.seg, s.dp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b1;
    tick_clk = 1'b0;
    run      = 1'b0;
    clear    = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    snap("reset_state", 16'h0000);
    @(negedge clk_in);
    #1;
    reset    = 1'b0;
    prev_dig = 16'h0000;
    last_exp = 16'h0000;
    armed    = 1'b1;
    @(posedge clk_in);
    #1;

    run = 1'b1;
    repeat (10) tick(8, 8);
    snap("count10", 16'h0010);
    scan("scan0010", 16'h0010);

    clear = 1'b1;
    push_cnt(0);
    @(posedge clk_in);
    #1 clear = 1'b0;
    @(posedge clk_in);
    #1;

    tick_clk = 1'b1;
    push_cnt(1);
    @(posedge clk_in);
    #1 snap("lat_k", 16'h0000);
    @(posedge clk_in);
    #1 snap("lat_k1", 16'h0000);
    @(posedge clk_in);
    #1 snap("lat_k2", 16'h0001);
    tick_clk = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;

    repeat (6) tick(3, 3);
    snap("at_0007", 16'h0007);
    run = 1'b0;
    repeat (3) tick(3, 3);
    snap("hold_0007", 16'h0007);
    run = 1'b1;

    tick_clk = 1'b1;
    @(posedge clk_in);
    #1;
    @(posedge clk_in);
    #1 clear = 1'b1;
    push_cnt(0);
    @(posedge clk_in);
    #1 clear = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 tick_clk = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 snap("clear_tick", 16'h0000);

    repeat (3599) tick(3, 3);
    snap("at_5959", 16'h5959);
    scan("scan5959", 16'h5959);
    tick(3, 3);
    repeat (4) @(posedge clk_in);
    #1 snap("after_wrap", 16'h0000);

    repeat (754) tick(3, 3);
    snap("at_1234", 16'h1234);
    scan("scan1234", 16'h1234);

    tick_clk = 1'b1;
    @(posedge clk_in);
    #1;
    @(posedge clk_in);
    #1 reset = 1'b1;
    tick_clk = 1'b0;
    push_cnt(0);
    @(posedge clk_in);
    #1 snap("reset_mid", 16'h0000);
    @(posedge clk_in);
    #1 reset = 1'b0;
    repeat (10) @(posedge clk_in);
    #1 snap("reset_after", 16'h0000);

    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if (dig_q.size() != 0) begin
      errors++;
      $display("FAIL digit_queue: got %0d pending changes, want 0", dig_q.size());
    end
    checks++;
    if (wrap_exp != 0) begin
      errors++;
      $display("FAIL wrap_count: got %0d missing pulses, want 0", wrap_exp);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
